block_max_exp_collector: RTL and testbench



---
 rtl/block_max_exp_collector_if.sv | 26 ++
 rtl/block_max_exp_collector.sv | 163 ++++++++++++++++
 tb/tb_block_max_exp_collector.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/block_max_exp_collector_if.sv
// Stream-in / block-out handshake bundle for block_max_exp_collector.
// slave = the collector, master = the upstream sender plus downstream consumer.
interface block_max_exp_collector_if #(
  parameter int expWidth = 4,
  parameter int BLOCK    = 64,
  parameter int LANES    = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*expWidth-1:0] in_exp;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [BLOCK*expWidth-1:0] out_exp;
  logic [expWidth-1:0]       out_max;

  modport master (
    output in_valid, in_exp, in_last, out_ready,
    input  in_ready, out_valid, out_exp, out_max
  );

  modport slave (
    input  in_valid, in_exp, in_last, out_ready,
    output in_ready, out_valid, out_exp, out_max
  );
endinterface

// File: rtl/block_max_exp_collector.sv
// Buffers a 64-exponent block arriving LANES per beat and tracks its maximum exponent.
// Define MAXEXP_PINGPONG_EN for two alternating block buffers (collect while holding).
module block_max_exp_collector #(
  parameter int expWidth = 4,
  parameter int BLOCK    = 64,
  parameter int LANES    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  block_max_exp_collector_if.slave  bus,
  output logic                      err_last
);
  localparam int BEATS   = BLOCK / LANES;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLICE_W = LANES * expWidth;
  localparam int VEC_W   = BLOCK * expWidth;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (BLOCK % LANES != 0) begin : g_bad_cfg
    $error("block_max_exp_collector: BLOCK must be a multiple of LANES");
  end

  logic                in_ready;
  logic                out_valid;
  logic [CNT_W-1:0]    beat_cnt;
  logic [expWidth-1:0] run_max;
  logic [expWidth-1:0] next_max;
  logic                in_fire;
  logic                last_beat;

  assign in_fire      = bus.in_valid && in_ready;
  assign last_beat    = (beat_cnt == LAST_BEAT);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;

  // NOTE: blocking '=' is correct here: each lane compares against the running
  // result of the lanes before it within the same evaluation.
  always_comb begin
    next_max = run_max;
    for (int i = 0; i < LANES; i++) begin
      if (bus.in_exp[i*expWidth +: expWidth] > next_max)
        next_max = bus.in_exp[i*expWidth +: expWidth];
    end
  end

  // Beat counter and running max are shared by both buffer organisations.
  // NOTE: sequential state uses '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      run_max  <= '0;
      err_last <= 1'b0;
    end else if (in_fire) begin
      if (bus.in_last != last_beat) err_last <= 1'b1;
      if (last_beat) begin
        beat_cnt <= '0;
        run_max  <= '0;
      end else begin
        beat_cnt <= beat_cnt + CNT_W'(1);
        run_max  <= next_max;
      end
    end
  end

`ifdef MAXEXP_PINGPONG_EN
  logic [VEC_W-1:0]    bufs    [2];
  logic [expWidth-1:0] buf_max [2];
  logic [1:0]          full;
  logic [1:0]          full_n;
  logic                wr_sel;
  logic                rd_sel;
  logic                rd_sel_n;
  logic                out_fire;

  assign out_fire = out_valid && bus.out_ready;

  // wr_sel and rd_sel only coincide when both buffers are empty or both full,
  // so a release and a fill never target the same buffer in one cycle.
  always_comb begin
    full_n   = full;
    rd_sel_n = rd_sel;
    if (out_fire) begin
      full_n[rd_sel] = 1'b0;
      rd_sel_n       = ~rd_sel;
    end
    if (in_fire && last_beat) full_n[wr_sel] = 1'b1;
  end

  // NOTE: the block buffers feed out_exp, which must read 0 after reset,
  // so they are reset like ordinary registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bufs[0]    <= '0;
      bufs[1]    <= '0;
      buf_max[0] <= '0;
      buf_max[1] <= '0;
      full       <= '0;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      full      <= full_n;
      rd_sel    <= rd_sel_n;
      in_ready  <= ~&full_n;
      out_valid <= full_n[rd_sel_n];
      if (in_fire) begin
        bufs[wr_sel][int'(beat_cnt)*SLICE_W +: SLICE_W] <= bus.in_exp;
        if (last_beat) begin
          buf_max[wr_sel] <= next_max;
          wr_sel          <= ~wr_sel;
        end
      end
    end
  end

  assign bus.out_exp = bufs[rd_sel];
  assign bus.out_max = buf_max[rd_sel];
`else
  typedef enum logic {COLLECT, HOLD} state_t;

  state_t              state;
  logic [VEC_W-1:0]    out_exp_r;
  logic [expWidth-1:0] out_max_r;

  // The buffer doubles as the output register: it is only written in COLLECT,
  // so it stays stable for the whole HOLD phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= COLLECT;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_exp_r <= '0;
      out_max_r <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_fire) begin
            out_exp_r[int'(beat_cnt)*SLICE_W +: SLICE_W] <= bus.in_exp;
            if (last_beat) begin
              out_max_r <= next_max;
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state     <= COLLECT;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.out_exp = out_exp_r;
  assign bus.out_max = out_max_r;
`endif
endmodule

// File: tb/tb_block_max_exp_collector.sv
// Randomised and directed bench for block_max_exp_collector against a block-level
// reference model (assembled 64-slot vectors, plain max over slots, beat-index last check).
module tb_block_max_exp_collector;
  localparam int EW    = 4;
  localparam int BLK   = 64;
  localparam int LN    = 8;
  localparam int BEATS = BLK / LN;
  localparam int VW    = BLK * EW;
  localparam int BW    = LN * EW;
`ifdef MAXEXP_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic err_last;
  int   n_cmp = 0;
  int   n_bad = 0;

  block_max_exp_collector_if #(.expWidth(EW), .BLOCK(BLK), .LANES(LN)) bus ();

  block_max_exp_collector #(.expWidth(EW), .BLOCK(BLK), .LANES(LN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .err_last (err_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] vec;
    logic [EW-1:0] mx;
  } blk_t;

  blk_t          exp_q [$];
  logic [EW-1:0] cur [BLK];
  int            beat_idx = 0;
  logic          err_exp  = 1'b0;
  int            rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    beat_idx = 0;
    err_exp  = 1'b0;
  endtask

  // Reference: collect slots; on the BEATS-th beat the block and its max are queued.
  task automatic model_beat(input logic [BW-1:0] lanes, input logic last);
    for (int i = 0; i < LN; i++) cur[beat_idx*LN + i] = lanes[i*EW +: EW];
    if (last != (beat_idx == BEATS-1)) err_exp = 1'b1;
    if (beat_idx == BEATS-1) begin
      blk_t b;
      b.mx = '0;
      for (int k = 0; k < BLK; k++) begin
        b.vec[k*EW +: EW] = cur[k];
        if (cur[k] > b.mx) b.mx = cur[k];
      end
      exp_q.push_back(b);
      beat_idx = 0;
    end else begin
      beat_idx++;
    end
  endtask

  function automatic logic [VW-1:0] rand_vec(input int hi);
    logic [VW-1:0] v;
    for (int k = 0; k < BLK; k++) v[k*EW +: EW] = EW'($urandom_range(0, hi));
    return v;
  endfunction

  // Called at a negedge; returns at the negedge just after the handshake edge.
  task automatic send_beat(input logic [BW-1:0] lanes, input logic last);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_exp   = lanes;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("in_ready_timeout", 1'b0, 1'b1);
    else model_beat(lanes, last);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_block(input logic [VW-1:0] vec, input int bad_last, input bit gaps);
    for (int b = 0; b < BEATS; b++) begin
      logic lst;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_exp = $urandom;
          @(negedge clk);
        end
      end
      lst = (b == BEATS-1);
      if (b == bad_last) lst = ~lst;
      send_beat(vec[b*BW +: BW], lst);
    end
  endtask

  task automatic drain();
    int t = 0;
    rdy_mode = 1;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.out_ready = ($urandom_range(0, 3) != 0);
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Every cycle with out_valid, the presented block must be the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", bus.out_valid, 1'b0);
        end else begin
          check("out_max", bus.out_max, exp_q[0].mx);
          check("out_exp", bus.out_exp, exp_q[0].vec);
          if (bus.out_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] v;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_exp   = '0;
    bus.in_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_exp",   bus.out_exp,   '0);
    check("rst_out_max",   bus.out_max,   '0);
    check("rst_err_last",  err_last,      1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single block, fixed lane pattern, consumer always ready.
    rdy_mode = 1;
    @(negedge clk);
    send_block({BEATS{32'h3765_4321}}, -1, 1'b0);
    check("t1_out_valid", bus.out_valid, 1'b1);
    check("t1_in_ready",  bus.in_ready,  PP);
    check("t1_out_max",   bus.out_max,   4'd7);
    check("t1_out_exp",   bus.out_exp,   {BEATS{32'h3765_4321}});
    @(negedge clk);
    check("t1_valid_drop", bus.out_valid, 1'b0);
    check("t1_ready_back", bus.in_ready,  1'b1);

    // Backpressure for 5 cycles, accept on the 6th.
    rdy_mode = 2;
    @(negedge clk);
    send_block(rand_vec(15), -1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_in_ready",  bus.in_ready,  PP);
      if (i == 4) rdy_mode = 1;
      @(negedge clk);
    end
    check("bp_valid_c6", bus.out_valid, 1'b1);
    @(negedge clk);
    check("bp_valid_drop", bus.out_valid, 1'b0);
    check("bp_ready_back", bus.in_ready,  1'b1);

    // All-zero block, then a block whose only 15 is beat 7 lane 7.
    send_block('0, -1, 1'b0);
    check("zero_max", bus.out_max, 4'd0);
    check("zero_exp", bus.out_exp, '0);
    v = rand_vec(14);
    v[VW-1 -: EW] = 4'd15;
    send_block(v, -1, 1'b0);
    check("sat_max", bus.out_max, 4'd15);
    drain();

    // Reset after 4 beats carrying a 12; next full block has max 5.
    v = rand_vec(11);
    v[$urandom_range(0, 4*LN-1)*EW +: EW] = 4'd12;
    for (int b = 0; b < 4; b++) send_beat(v[b*BW +: BW], 1'b0);
    pulse_reset();
    check("mid_rst_in_ready",  bus.in_ready,  1'b1);
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    v = rand_vec(4);
    v[$urandom_range(0, BLK-1)*EW +: EW] = 4'd5;
    send_block(v, -1, 1'b0);
    check("mid_rst_max", bus.out_max, 4'd5);
    check("mid_rst_err", err_last,    1'b0);
    drain();

    // in_last on beat 3: flagged, sticky, data flow unaffected.
    v = rand_vec(15);
    send_block(v, 3, 1'b0);
    check("last_err_set", err_last,    1'b1);
    check("last_err_max", bus.out_max, exp_q[exp_q.size()-1].mx);
    send_block(rand_vec(15), -1, 1'b0);
    check("last_err_sticky", err_last, 1'b1);
    drain();

    // Randomised traffic: random gaps, random backpressure, occasional bad in_last.
    pulse_reset();
    rdy_mode = 0;
    for (int n = 0; n < 24; n++) begin
      int bad;
      bad = ($urandom_range(0, 9) == 0) ? $urandom_range(0, BEATS-1) : -1;
      send_block(rand_vec($urandom_range(0, 15)), bad, 1'b1);
      check("rand_err_last", err_last, err_exp);
    end
    drain();

`ifdef MAXEXP_PINGPONG_EN
    // Two blocks collected back to back while the consumer stalls.
    pulse_reset();
    rdy_mode = 2;
    @(negedge clk);
    v = rand_vec(8);
    v[$urandom_range(0, BLK-1)*EW +: EW] = 4'd9;
    send_block(v, -1, 1'b0);
    check("pp_ready_mid", bus.in_ready, 1'b1);
    v = rand_vec(3);
    v[$urandom_range(0, BLK-1)*EW +: EW] = 4'd4;
    send_block(v, -1, 1'b0);
    check("pp_ready_full", bus.in_ready,  1'b0);
    check("pp_first_max",  bus.out_max,   4'd9);
    rdy_mode = 1;
    @(negedge clk);
    check("pp_first_held", bus.out_max, 4'd9);
    @(negedge clk);
    check("pp_second_max",   bus.out_max,   4'd4);
    check("pp_second_valid", bus.out_valid, 1'b1);
    check("pp_ready_free",   bus.in_ready,  1'b1);
    @(negedge clk);
    check("pp_valid_drop", bus.out_valid, 1'b0);
    drain();
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
